// File: rtl/bus_arbiter_rr.sv
// N-master bus arbiter with round-robin grant and serial (LSB-first) slave-address capture.
// Build option: define ARB_FIXED_PRIO_EN for fixed lowest-index priority with preemption.
module bus_arbiter_rr #(
  parameter int unsigned NUM_MASTERS  = 4,
  parameter int unsigned SLAVE_ADDR_W = 2,
  parameter int unsigned IDX_W        = $clog2(NUM_MASTERS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_MASTERS-1:0]  m_request,
  input  logic [NUM_MASTERS-1:0]  m_slave_select,
  output logic [NUM_MASTERS-1:0]  m_grant,
  output logic                    busy,
  output logic [SLAVE_ADDR_W-1:0] slave_grant,
  output logic [IDX_W-1:0]        bus_grant
);

  localparam int unsigned PTR_W = $clog2(NUM_MASTERS);
  localparam int unsigned CNT_W = $clog2(SLAVE_ADDR_W + 1);
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_MASTERS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLAVE_ADDR_W - 1);

  typedef enum logic [1:0] {IDLE, ADDR, ACTIVE} state_e;

  state_e                  state_q;
  logic [PTR_W-1:0]        ptr_q;
  logic [PTR_W-1:0]        cur_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [NUM_MASTERS-1:0]  grant_q;
  logic                    busy_q;
  logic [SLAVE_ADDR_W-1:0] sg_q;
  logic [IDX_W-1:0]        bg_q;

  logic                    win_found;
  logic [PTR_W-1:0]        win_idx;
  logic                    preempt;
  logic                    cur_release;
  logic                    launch;

  // In the fixed-priority build ptr_q never leaves NUM_MASTERS-1, so the
  // same search degenerates to lowest-index-first.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (!win_found && m_request[i] && (i == (32'(ptr_q) + k) % NUM_MASTERS)) begin
          win_found = 1'b1;
          win_idx   = PTR_W'(i);
        end
      end
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign preempt = (state_q != IDLE) && win_found && (win_idx < cur_q);
`else
  assign preempt = 1'b0;
`endif

  assign cur_release = (state_q != IDLE) && !m_request[cur_q];
  assign launch      = win_found && ((state_q == IDLE) || cur_release || preempt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      cur_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      sg_q    <= '0;
      bg_q    <= '0;
    end else if (launch) begin
      state_q <= ADDR;
      cur_q   <= win_idx;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q   <= win_idx;
`endif
      cnt_q   <= '0;
      grant_q <= NUM_MASTERS'(1) << win_idx;
      busy_q  <= 1'b1;
      sg_q    <= '0;
      bg_q    <= IDX_W'(win_idx) + IDX_W'(1);
    end else if (cur_release) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      sg_q    <= '0;
      bg_q    <= '0;
    end else if (state_q == ADDR) begin
      for (int unsigned i = 0; i < SLAVE_ADDR_W; i++) begin
        if (cnt_q == CNT_W'(i)) sg_q[i] <= m_slave_select[cur_q];
      end
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        busy_q  <= 1'b0;
        state_q <= ACTIVE;
      end
    end
  end

  assign m_grant     = grant_q;
  assign busy        = busy_q;
  assign slave_grant = sg_q;
  assign bus_grant   = bg_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Table-driven, scoreboard-checked bench for bus_arbiter_rr (NUM_MASTERS=4, SLAVE_ADDR_W=2).
module tb_bus_arbiter_rr;

  localparam int unsigned NM = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned IW = $clog2(NM + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [NM-1:0] m_request;
  logic [NM-1:0] m_slave_select;
  logic [NM-1:0] m_grant;
  logic          busy;
  logic [AW-1:0] slave_grant;
  logic [IW-1:0] bus_grant;

  bus_arbiter_rr #(.NUM_MASTERS(NM), .SLAVE_ADDR_W(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .m_request      (m_request),
    .m_slave_select (m_slave_select),
    .m_grant        (m_grant),
    .busy           (busy),
    .slave_grant    (slave_grant),
    .bus_grant      (bus_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NM-1:0] req;
    logic [NM-1:0] sel;
    logic [NM-1:0] grant;
    logic          bsy;
    logic [AW-1:0] sg;
    logic [IW-1:0] bg;
  } vec_t;

  typedef struct {
    string         name;
    logic [NM-1:0] grant;
    logic          bsy;
    logic [AW-1:0] sg;
    logic [IW-1:0] bg;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic rst, input logic [NM-1:0] req, input logic [NM-1:0] sel,
                              input logic [NM-1:0] grant, input logic bsy,
                              input logic [AW-1:0] sg, input logic [IW-1:0] bg);
    vec_t v;
    v.rst = rst; v.req = req; v.sel = sel;
    v.grant = grant; v.bsy = bsy; v.sg = sg; v.bg = bg;
    return v;
  endfunction

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (m_grant !== e.grant || busy !== e.bsy || slave_grant !== e.sg || bus_grant !== e.bg) begin
      errors++;
      $display("FAIL %s: got m_grant=%b busy=%b slave_grant=%b bus_grant=%0d, expected m_grant=%b busy=%b slave_grant=%b bus_grant=%0d",
               e.name, m_grant, busy, slave_grant, bus_grant, e.grant, e.bsy, e.sg, e.bg);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    exp_t e;
    reset          = v.rst;
    m_request      = v.req;
    m_slave_select = v.sel;
    e.name = name; e.grant = v.grant; e.bsy = v.bsy; e.sg = v.sg; e.bg = v.bg;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; m_request = '0; m_slave_select = '0;
    #1;

    // reset and idle
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 2'b00, 3'd0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 2'b00, 3'd0));

`ifndef ARB_FIXED_PRIO_EN
    // single master 2, address bits 1 then 0
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 1, 2'b00, 3'd3));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100, 1, 2'b01, 3'd3));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 0, 2'b01, 3'd3));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 0, 2'b01, 3'd3));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 2'b00, 3'd0));
    // all request: order 0,1,2,3,0 with zero-idle handover
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 2'b00, 3'd0));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 1, 2'b00, 3'd1));
    tbl.push_back(mk(0, 4'b1111, 4'b0001, 4'b0001, 1, 2'b01, 3'd1));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0001, 0, 2'b01, 3'd1));
    tbl.push_back(mk(0, 4'b1110, 4'b0000, 4'b0010, 1, 2'b00, 3'd2));
    tbl.push_back(mk(0, 4'b1111, 4'b0010, 4'b0010, 1, 2'b01, 3'd2));
    tbl.push_back(mk(0, 4'b1111, 4'b0010, 4'b0010, 0, 2'b11, 3'd2));
    tbl.push_back(mk(0, 4'b1101, 4'b0000, 4'b0100, 1, 2'b00, 3'd3));
    tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0100, 1, 2'b00, 3'd3));
    tbl.push_back(mk(0, 4'b1111, 4'b0100, 4'b0100, 0, 2'b10, 3'd3));
    tbl.push_back(mk(0, 4'b1011, 4'b0000, 4'b1000, 1, 2'b00, 3'd4));
    tbl.push_back(mk(0, 4'b1111, 4'b1000, 4'b1000, 1, 2'b01, 3'd4));
    tbl.push_back(mk(0, 4'b1111, 4'b1000, 4'b1000, 0, 2'b11, 3'd4));
    tbl.push_back(mk(0, 4'b0111, 4'b0000, 4'b0001, 1, 2'b00, 3'd1));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 2'b00, 3'd0));
    // release during ADDR: master 1 drops after one bit, master 3 pending
    tbl.push_back(mk(0, 4'b1010, 4'b0000, 4'b0010, 1, 2'b00, 3'd2));
    tbl.push_back(mk(0, 4'b1010, 4'b0010, 4'b0010, 1, 2'b01, 3'd2));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 1, 2'b00, 3'd4));
    tbl.push_back(mk(0, 4'b1000, 4'b0000, 4'b1000, 1, 2'b00, 3'd4));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 4'b1000, 0, 2'b10, 3'd4));
    // non-preemption: master 3 ACTIVE, master 0 requests
    tbl.push_back(mk(0, 4'b1001, 4'b0000, 4'b1000, 0, 2'b10, 3'd4));
    tbl.push_back(mk(0, 4'b1001, 4'b1111, 4'b1000, 0, 2'b10, 3'd4));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 1, 2'b00, 3'd1));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 1, 2'b01, 3'd1));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0, 2'b01, 3'd1));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 2'b00, 3'd0));
`else
    // fixed priority: master 2 ACTIVE, master 0 preempts
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 1, 2'b00, 3'd3));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100, 1, 2'b01, 3'd3));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100, 0, 2'b11, 3'd3));
    tbl.push_back(mk(0, 4'b0101, 4'b0000, 4'b0001, 1, 2'b00, 3'd1));
    tbl.push_back(mk(0, 4'b0101, 4'b0001, 4'b0001, 1, 2'b01, 3'd1));
    tbl.push_back(mk(0, 4'b0101, 4'b0000, 4'b0001, 0, 2'b01, 3'd1));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 2'b00, 3'd0));
`endif

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

    // reset mid-ADDR, then pointer must be back at NUM_MASTERS-1 (master 0 beats 3)
    step("mid_reset_pre",   mk(1, 4'b0000, 4'b0000, 4'b0000, 0, 2'b00, 3'd0));
    step("mid_reset_grant", mk(0, 4'b0100, 4'b0000, 4'b0100, 1, 2'b00, 3'd3));
    step("mid_reset_bit0",  mk(0, 4'b0100, 4'b0100, 4'b0100, 1, 2'b01, 3'd3));
    step("mid_reset_apply", mk(1, 4'b0100, 4'b0100, 4'b0000, 0, 2'b00, 3'd0));
    step("mid_reset_idle",  mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 2'b00, 3'd0));
    step("post_reset_ptr",  mk(0, 4'b1001, 4'b0000, 4'b0001, 1, 2'b00, 3'd1));
    step("post_reset_end",  mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 2'b00, 3'd0));

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
